// File: rtl/ysyx_25040105_ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ysyx_25040105_ifu_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int          INST_W       = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INST_W-1:0]   inst;
    } ifu_entry_t;
endpackage

// File: rtl/ysyx_25040105_ifu_fifo.sv
// Synchronous instruction buffer; flush wins over push/pop, and a push into
// a full buffer is accepted when a pop happens in the same cycle.
module ysyx_25040105_ifu_fifo
    import ysyx_25040105_ifu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ifu_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && !rst) mem_r[wr_ptr_r] <= wdata;
    end
endmodule

// File: rtl/ysyx_25040105_ifu_prefetch_chk.sv
// Invariant checker for the prefetch IFU credit and drop bookkeeping.
module ysyx_25040105_ifu_prefetch_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          mem_rsp_valid,
    input logic [CW-1:0] out_cnt,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] fifo_cnt
);
    a_credit: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, out_cnt} + {1'b0, fifo_cnt}) <= (CW+1)'(DEPTH)));

    a_drop: assert property (@(posedge clk) disable iff (rst)
        (drop_cnt <= out_cnt));

    a_rsp: assert property (@(posedge clk) disable iff (rst)
        !(mem_rsp_valid && (out_cnt == CW'(0))));
endmodule

// File: rtl/ysyx_25040105_ifu_prefetch.sv
// Prefetching IFU: credit-limited request issue, in-order response buffering,
// redirect flush with stale-response dropping. Option: IFU_RSP_BYPASS_EN.
module ysyx_25040105_ifu_prefetch
    import ysyx_25040105_ifu_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst,
    input  logic            inst_ready
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [CW-1:0]   out_cnt_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   fifo_cnt_s;
    logic [CW-1:0]   rsp_dec_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            req_fire_s;
    logic            keep_s;
    logic            push_s;
    logic            pop_s;
    logic            take_byp_s;
    ifu_entry_t      wr_entry_s;
    ifu_entry_t      head_s;

    // Buffered entries count against the request credit so a push can never overflow.
    assign mem_req_valid = !rst && !redirect_valid &&
                           (({1'b0, out_cnt_r} + {1'b0, fifo_cnt_s}) < DEPTH_OCC);
    assign mem_req_addr  = fetch_pc_r;
    assign req_fire_s    = mem_req_valid && mem_req_ready;
    assign rsp_dec_s     = CW'(mem_rsp_valid);
    assign keep_s        = mem_rsp_valid && (drop_cnt_r == CW'(0)) && !redirect_valid;
    assign push_s        = keep_s && !take_byp_s;
    assign pop_s         = !fifo_empty_s && inst_ready && !redirect_valid;

    // Decode-side presentation and FIFO write entry.
    always_comb begin
        wr_entry_s      = '{pc: XLEN_DEF'(rsp_pc_r), inst: mem_rsp_data};
        take_byp_s      = 1'b0;
`ifdef IFU_RSP_BYPASS_EN
        if (fifo_empty_s && keep_s) begin
            inst_valid = 1'b1;
            inst_pc    = rsp_pc_r;
            inst       = mem_rsp_data;
            take_byp_s = inst_ready;
        end else begin
            inst_valid = !fifo_empty_s && !redirect_valid;
            inst_pc    = XLEN'(head_s.pc);
            inst       = head_s.inst;
        end
`else
        inst_valid = !fifo_empty_s && !redirect_valid;
        inst_pc    = XLEN'(head_s.pc);
        inst       = head_s.inst;
`endif
    end

    // Fetch/response PCs and outstanding/drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            out_cnt_r  <= CW'(0);
            drop_cnt_r <= CW'(0);
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
            rsp_pc_r   <= {redirect_pc[XLEN-1:2], 2'b00};
            out_cnt_r  <= out_cnt_r - rsp_dec_s;
            drop_cnt_r <= out_cnt_r - rsp_dec_s;
        end else begin
            if (req_fire_s) fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
            out_cnt_r <= out_cnt_r + CW'(req_fire_s) - rsp_dec_s;
            if (mem_rsp_valid) begin
                if (drop_cnt_r != CW'(0)) drop_cnt_r <= drop_cnt_r - CW'(1);
                else rsp_pc_r <= rsp_pc_r + XLEN'(PC_STEP);
            end
        end
    end

    ysyx_25040105_ifu_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (ifu_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata (wr_entry_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    ysyx_25040105_ifu_prefetch_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk           (clk),
        .rst           (rst),
        .mem_rsp_valid (mem_rsp_valid),
        .out_cnt       (out_cnt_r),
        .drop_cnt      (drop_cnt_r),
        .fifo_cnt      (fifo_cnt_s)
    );

    logic unused_s;
    assign unused_s = fifo_full_s;
endmodule

// File: tb/tb_ysyx_25040105_ifu_prefetch.sv
// Randomized bench for the prefetch IFU against a queue-based fetch/stream model.
module tb_ysyx_25040105_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready = 1'b0;

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    req_t        pend_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] next_req;
    int          checks = 0;
    int          passes = 0;

    // Values sampled by the most recent cycle, for the scenario tasks.
    logic        samp_rv, samp_iv, samp_fire, samp_pop;
    logic [31:0] samp_addr, samp_ipc;

    ysyx_25040105_ifu_prefetch #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One clock: drive at negedge, compare at +1, advance the model at posedge.
    task automatic cycle(input bit do_rst, input bit redir, input logic [31:0] tgt,
                         input int rsp_pct, input int rdy_pct, input int irdy_pct);
        bit rsp, keep, byp, exp_rv, exp_iv;
        logic [31:0] exp_pc;
        req_t h;
        keep = 1'b0; byp = 1'b0; exp_rv = 1'b0; exp_iv = 1'b0;
        @(negedge clk);
        rst            = do_rst;
        redirect_valid = redir;
        redirect_pc    = tgt;
        rsp            = !do_rst && (pend_q.size() > 0) && ($urandom_range(99) < rsp_pct);
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? inst_of(pend_q[0].addr) : $urandom;
        mem_req_ready  = ($urandom_range(99) < rdy_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        #1;
        samp_rv = mem_req_valid; samp_addr = mem_req_addr;
        samp_iv = inst_valid;    samp_ipc  = inst_pc;
        if (do_rst) begin
            checks++;
            if (mem_req_valid !== 1'b0) $display("FAIL req_valid_in_reset: got %b want 0", mem_req_valid);
            else passes++;
        end else begin
            exp_rv = !redir && (pend_q.size() + buf_q.size() < DEPTH);
            checks++;
            if (mem_req_valid !== exp_rv) $display("FAIL req_valid: got %b want %b", mem_req_valid, exp_rv);
            else passes++;
            if (exp_rv) begin
                checks++;
                if (mem_req_addr !== next_req) $display("FAIL req_addr: got %h want %h", mem_req_addr, next_req);
                else passes++;
            end
            if (rsp) keep = !redir && !pend_q[0].stale;
`ifdef IFU_RSP_BYPASS_EN
            byp = keep && (buf_q.size() == 0);
`endif
            exp_iv = !redir && ((buf_q.size() > 0) || byp);
            checks++;
            if (inst_valid !== exp_iv) $display("FAIL inst_valid: got %b want %b", inst_valid, exp_iv);
            else passes++;
            if (exp_iv) begin
                exp_pc = byp ? pend_q[0].addr : buf_q[0];
                checks++;
                if (inst_pc !== exp_pc || inst !== inst_of(exp_pc))
                    $display("FAIL inst_out: got pc %h inst %h want pc %h inst %h", inst_pc, inst, exp_pc, inst_of(exp_pc));
                else passes++;
            end
        end
        samp_fire = exp_rv && mem_req_ready;
        samp_pop  = exp_iv && inst_ready;
        @(posedge clk);
        if (do_rst) begin
            pend_q.delete(); buf_q.delete(); next_req = RESET_PC;
        end else if (redir) begin
            buf_q.delete();
            if (rsp) h = pend_q.pop_front();
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            next_req = {tgt[31:2], 2'b00};
        end else begin
            if (samp_pop && !byp) void'(buf_q.pop_front());
            if (rsp) begin
                h = pend_q.pop_front();
                if (!h.stale && !(byp && inst_ready)) buf_q.push_back(h.addr);
            end
            if (samp_fire) begin
                pend_q.push_back('{next_req, 1'b0});
                next_req = next_req + 32'd4;
            end
        end
    endtask

    task automatic apply_reset();
        cycle(1'b1, 1'b0, 32'h0, 0, 0, 0);
        cycle(1'b1, 1'b0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
        else passes++;
        cycle(1'b0, 1'b0, 32'h0, 0, 0, 0);
        checks++;
        if (samp_rv !== 1'b1 || samp_addr !== 32'h8000_0000)
            $display("FAIL reset_first_req: got v=%b a=%h want v=1 a=80000000", samp_rv, samp_addr);
        else passes++;
    endtask

    task automatic test_stream();
        int pops;
        pops = 0;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 100, 100, 100);
            if (i >= 4 && samp_pop) pops++;
        end
        checks++;
        if (pops !== 36) $display("FAIL stream_throughput: got %0d pops want 36", pops);
        else passes++;
    endtask

    task automatic test_backpressure();
        int fires, pops;
        fires = 0; pops = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 50, 100, 0);
            if (samp_fire) fires++;
        end
        checks++;
        if (fires !== DEPTH) $display("FAIL backpressure_fires: got %0d want %0d", fires, DEPTH);
        else passes++;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) $display("FAIL backpressure_stall: got %b want 0", mem_req_valid);
        else passes++;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 100, 0, 100);
            if (samp_pop) pops++;
        end
        checks++;
        if (pops !== DEPTH) $display("FAIL backpressure_drain: got %0d want %0d", pops, DEPTH);
        else passes++;
    endtask

    task automatic check_first_pop(input logic [31:0] want);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 100, 100, 100);
            if (samp_pop) begin
                found = 1'b1;
                checks++;
                if (samp_ipc !== want) $display("FAIL first_pop_pc: got %h want %h", samp_ipc, want);
                else passes++;
            end
        end
        if (!found) begin
            checks++;
            $display("FAIL first_pop_timeout: got none want pc %h", want);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 0, 100, 100);
        cycle(1'b0, 1'b1, 32'h8000_1002, 0, 100, 100);
        checks++;
        if (samp_rv !== 1'b0) $display("FAIL redirect_no_req: got %b want 0", samp_rv);
        else passes++;
        cycle(1'b0, 1'b0, 32'h0, 0, 100, 100);
        checks++;
        if (samp_rv !== 1'b1 || samp_addr !== 32'h8000_1000)
            $display("FAIL redirect_target: got v=%b a=%h want v=1 a=80001000", samp_rv, samp_addr);
        else passes++;
        check_first_pop(32'h8000_1000);
    endtask

    task automatic test_redirect_with_rsp();
        apply_reset();
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 32'h0, 0, 100, 100);
        cycle(1'b0, 1'b1, 32'h8000_2000, 100, 100, 100);
        checks++;
        if (samp_iv !== 1'b0) $display("FAIL redirect_masks_inst: got %b want 0", samp_iv);
        else passes++;
        check_first_pop(32'h8000_2000);
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        int n;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        n = 0;
        apply_reset();
        cycle(1'b0, 1'b1, 32'hFFFF_FFFB, 0, 100, 100);
        for (int i = 0; i < 20 && n < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 100, 100, 100);
            if (samp_fire) begin
                checks++;
                if (samp_addr !== want[n]) $display("FAIL wrap_addr%0d: got %h want %h", n, samp_addr, want[n]);
                else passes++;
                n++;
            end
        end
        if (n < 3) begin
            checks++;
            $display("FAIL wrap_timeout: got %0d fires want 3", n);
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 100, 100, 0);
        cycle(1'b1, 1'b0, 32'h0, 0, 0, 0);
        #1;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0)
            $display("FAIL midreset_outputs: got iv=%b rv=%b want 0 0", inst_valid, mem_req_valid);
        else passes++;
        cycle(1'b0, 1'b0, 32'h0, 0, 100, 100);
        checks++;
        if (samp_rv !== 1'b1 || samp_addr !== RESET_PC)
            $display("FAIL midreset_restart: got v=%b a=%h want v=1 a=%h", samp_rv, samp_addr, RESET_PC);
        else passes++;
        check_first_pop(RESET_PC);
    endtask

    task automatic test_random();
        bit r, d;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(199) == 0);
            d = ($urandom_range(99) < 4);
            cycle(r, d, $urandom, $urandom_range(100), $urandom_range(100), $urandom_range(100));
        end
    endtask

    initial begin
        next_req = RESET_PC;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_with_rsp();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
